// File: rtl/bit_mapper.sv
// Streaming constellation mapper: gathers 1/2/4/6 serial bits per group and
// emits one sign-magnitude {I,Q} symbol per group over a valid/ready output.
module bit_mapper #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mod,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_sym,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] sym_count
);

  logic [2:0]       cnt_q, cnt_d;
  logic [5:0]       sr_q, sr_d;
  logic [1:0]       mod_q, mod_d;
  logic [7:0]       sym_q, sym_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;

  logic [1:0] mod_eff;
  logic [2:0] last_idx;
  logic       is_last, accept, complete, xfer;
  logic [5:0] bits_full;

  // 16-QAM level: sign = ~v[0], magnitude 1 when v[1] else 3
  function automatic logic [3:0] nib16(input logic [1:0] v);
    return {~v[0], 1'b0, ~v[1], 1'b1};
  endfunction

  function automatic logic [3:0] nib64(input logic [2:0] v);
    logic [2:0] mag;
    case (v[2:1])
      2'b01:   mag = 3'd1;
      2'b11:   mag = 3'd3;
      2'b10:   mag = 3'd5;
      default: mag = 3'd7;
    endcase
    return {~v[0], mag};
  endfunction

  function automatic logic [7:0] map_sym(input logic [1:0] m, input logic [5:0] b);
    logic [3:0] i_n, q_n;
    case (m)
      2'd0: begin
        i_n = b[0] ? 4'h1 : 4'h9;
        q_n = 4'h0;
      end
      2'd1: begin
        i_n = b[0] ? 4'h1 : 4'h9;
        q_n = b[1] ? 4'h1 : 4'h9;
      end
      2'd2: begin
        i_n = nib16(b[1:0]);
        q_n = nib16(b[3:2]);
      end
      default: begin
        i_n = nib64(b[2:0]);
        q_n = nib64(b[5:3]);
      end
    endcase
    return {i_n, q_n};
  endfunction

  // The live mod input governs group size only until the first bit latches it
  assign mod_eff = (cnt_q == 3'd0) ? mod : mod_q;

  always_comb begin
    case (mod_eff)
      2'd0:    last_idx = 3'd0;
      2'd1:    last_idx = 3'd1;
      2'd2:    last_idx = 3'd3;
      default: last_idx = 3'd5;
    endcase
  end

  assign is_last  = (cnt_q == last_idx);
  assign in_ready = !vld_q || out_ready || !is_last;
  assign accept   = in_valid && in_ready;
  assign complete = accept && is_last;
  assign xfer     = vld_q && out_ready;

  always_comb begin
    bits_full        = sr_q;
    bits_full[cnt_q] = in_bit;
  end

  always_comb begin
    cnt_d  = cnt_q;
    sr_d   = sr_q;
    mod_d  = mod_q;
    sym_d  = sym_q;
    vld_d  = vld_q;
    scnt_d = scnt_q;
    if (accept) begin
      if (cnt_q == 3'd0) mod_d = mod;
      if (is_last) begin
        cnt_d = 3'd0;
        sr_d  = '0;
      end else begin
        cnt_d = cnt_q + 3'd1;
        sr_d  = bits_full;
      end
    end
    if (complete) begin
      sym_d = map_sym(mod_eff, bits_full);
      vld_d = 1'b1;
    end else if (xfer) begin
      vld_d = 1'b0;
    end
    if (xfer) scnt_d = scnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sr_q   <= '0;
      mod_q  <= '0;
      sym_q  <= '0;
      vld_q  <= 1'b0;
      scnt_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      sr_q   <= sr_d;
      mod_q  <= mod_d;
      sym_q  <= sym_d;
      vld_q  <= vld_d;
      scnt_q <= scnt_d;
    end
  end

  assign out_sym   = sym_q;
  assign out_valid = vld_q;
  assign sym_count = scnt_q;

endmodule

// File: tb/tb_bit_mapper.sv
// Bench for bit_mapper: constant vector table, handshake/reset sequences,
// a 64-QAM demap sweep and random traffic against a queue-based model.
module tb_bit_mapper;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    mod = '0;
  logic          in_bit = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic          in_ready, out_valid;
  logic [7:0]    out_sym;
  logic [CW-1:0] sym_count;

  bit_mapper #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .mod(mod), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(in_ready), .out_sym(out_sym), .out_valid(out_valid),
    .out_ready(out_ready), .sym_count(sym_count)
  );

  always #5 clk = ~clk;

  int pass_n = 0, total_n = 0;
  int t16[4] = '{'hB, 'h3, 'h9, 'h1};
  int t64[8] = '{'hF, 'h7, 'h9, 'h1, 'hD, 'h5, 'hB, 'h3};

  int  m_q[$];
  int  m_mod, m_sym, m_cnt;
  bit  m_vld;
  bit  ir_s;

  task automatic check(input string nm, input int act, input int exp);
    total_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic int nbits(input int md);
    case (md)
      0: return 1;
      1: return 2;
      2: return 4;
      default: return 6;
    endcase
  endfunction

  function automatic int ref_map(input int md, input int bv);
    int i_n, q_n;
    case (md)
      0: begin i_n = (bv & 1) ? 1 : 9; q_n = 0; end
      1: begin i_n = (bv & 1) ? 1 : 9; q_n = (bv & 2) ? 1 : 9; end
      2: begin i_n = t16[bv & 3]; q_n = t16[(bv >> 2) & 3]; end
      default: begin i_n = t64[bv & 7]; q_n = t64[(bv >> 3) & 7]; end
    endcase
    return i_n * 16 + q_n;
  endfunction

  function automatic int demap64(input int sym);
    int iv, qv;
    iv = 0; qv = 0;
    for (int k = 0; k < 8; k++) begin
      if (t64[k] == ((sym >> 4) & 15)) iv = k;
      if (t64[k] == (sym & 15)) qv = k;
    end
    return qv * 8 + iv;
  endfunction

  // Called just after a rising edge; returns just after the next one.
  task automatic tick(input bit v, input bit b, input int md, input bit r);
    int  n, bv;
    bit  rdy, acc, xf;
    in_valid = v; in_bit = b; mod = md[1:0]; out_ready = r;
    #2;
    n   = nbits(m_q.size() == 0 ? md : m_mod);
    rdy = !m_vld || r || (m_q.size() != n - 1);
    check("in_ready", in_ready, rdy);
    ir_s = in_ready;
    acc = v && rdy;
    xf  = m_vld && r;
    @(posedge clk); #1;
    if (xf) m_cnt = (m_cnt + 1) % (1 << CW);
    if (acc) begin
      if (m_q.size() == 0) m_mod = md;
      m_q.push_back(b);
    end
    if (acc && m_q.size() == nbits(m_mod)) begin
      bv = 0;
      foreach (m_q[k]) bv |= m_q[k] << k;
      m_sym = ref_map(m_mod, bv);
      m_vld = 1'b1;
      m_q.delete();
    end else if (xf) begin
      m_vld = 1'b0;
    end
    check("out_valid", out_valid, m_vld);
    check("out_sym", out_sym, m_sym);
    check("sym_count", sym_count, m_cnt);
  endtask

  task automatic assert_reset();
    in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sym", out_sym, 0);
    check("rst_sym_count", sym_count, 0);
    check("rst_in_ready", in_ready, 1);
    m_q.delete(); m_mod = 0; m_sym = 0; m_cnt = 0; m_vld = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic send(input int md, input int n, input int bits, input bit r);
    for (int k = 0; k < n; k++) tick(1'b1, bit'((bits >> k) & 1), md, r);
  endtask

  typedef struct {
    int md;
    int n;
    int bits;
    int exp;
  } vec_t;

  vec_t vt[11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = '{0, 1, 1,    'h10};
    vt[1]  = '{0, 1, 0,    'h90};
    vt[2]  = '{1, 2, 1,    'h19};
    vt[3]  = '{2, 4, 3,    'h1B};
    vt[4]  = '{3, 6, 59,   'h13};
    vt[5]  = '{3, 6, 0,    'hFF};
    vt[6]  = '{2, 4, 0,    'hBB};
    vt[7]  = '{1, 2, 3,    'h11};
    vt[8]  = '{3, 6, 63,   'h33};
    vt[9]  = '{2, 4, 12,   'hB1};
    vt[10] = '{1, 2, 2,    'h91};

    assert_reset();
    release_reset();

    // Constant vectors; bits 1,0 in BPSK must leave sym_count at 2
    for (int i = 0; i < 11; i++) begin
      send(vt[i].md, vt[i].n, vt[i].bits, 1'b1);
      check($sformatf("vec%0d_sym", i), out_sym, vt[i].exp);
      check($sformatf("vec%0d_valid", i), out_valid, 1);
      if (i == 1) begin
        tick(1'b0, 1'b0, 0, 1'b1);
        check("bpsk_sym_count", sym_count, 2);
      end
    end
    tick(1'b0, 1'b0, 0, 1'b1);

    // Held output stalls only the completing bit
    send(2, 4, 3, 1'b0);
    check("held_sym", out_sym, 'h1B);
    send(2, 3, 4, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tick(1'b1, 1'b1, 2, 1'b0);
      check("stall_in_ready", ir_s, 0);
      check("stall_sym", out_sym, 'h1B);
      check("stall_valid", out_valid, 1);
    end
    tick(1'b1, 1'b1, 2, 1'b1);
    check("release_in_ready", ir_s, 1);
    check("release_sym", out_sym, 'h1B ^ 'h1B ^ 'hB1);
    check("release_valid", out_valid, 1);
    tick(1'b0, 1'b0, 2, 1'b1);

    // mod change mid-group is ignored until the group completes
    send(3, 2, 3, 1'b1);
    tick(1'b1, 1'b0, 0, 1'b1);
    tick(1'b1, 1'b1, 0, 1'b1);
    tick(1'b1, 1'b1, 0, 1'b1);
    check("modchg_pre_valid", out_valid, 0);
    tick(1'b1, 1'b1, 0, 1'b1);
    check("modchg_sym", out_sym, 'h13);
    tick(1'b1, 1'b1, 0, 1'b1);
    check("modchg_next_bpsk", out_sym, 'h10);
    tick(1'b0, 1'b0, 0, 1'b1);

    // Reset mid-group and with a symbol held
    send(3, 6, 21, 1'b0);
    send(3, 3, 7, 1'b0);
    assert_reset();
    release_reset();
    send(3, 5, 0, 1'b1);
    check("post_rst_partial_valid", out_valid, 0);
    tick(1'b1, 1'b0, 3, 1'b1);
    check("post_rst_sym", out_sym, 'hFF);
    tick(1'b0, 1'b0, 3, 1'b1);
    check("post_rst_count", sym_count, 1);

    // 64-QAM sweep with demap round trip
    for (int v = 0; v < 64; v++) begin
      send(3, 6, v, 1'b1);
      check("demap64", demap64(int'(out_sym)), v);
    end
    tick(1'b0, 1'b0, 0, 1'b1);

    // Random traffic, including gaps and backpressure
    for (int c = 0; c < 2500; c++)
      tick(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)), bit'($urandom_range(0, 9) < 7));

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
